// File: rtl/controlador_de_alarmas.sv
`default_nettype none
// ============================================================================
// Module     : controlador_de_alarmas
// Description: Alarm controller. It debounces four raw sensors and drives a
//              horn with acknowledge, silence and re-arm, a fan with a hold
//              time after its request drops, a latched power cut and a
//              latched cause register.
// Ports      : clk           - single clock, rising edge
//              reset         - synchronous, active-high
//              Temperatura   - raw over-temperature sensor
//              Manual        - raw manual alarm pushbutton
//              SobreCarga    - raw overload sensor
//              Humo          - raw smoke sensor
//              Reconocer     - operator acknowledge, sampled every cycle
//              Bocina        - horn (registered)
//              Extractor     - fan (registered)
//              Interrupcion  - power cut (registered, latched)
//              Causas[3:0]   - latched causes {Temperatura, Manual,
//                              SobreCarga, Humo} (registered)
// Revision   : 1.0 - initial release
// ============================================================================
module controlador_de_alarmas #(
    parameter int CICLOS_FILTRO    = 4,
    parameter int CICLOS_EXTRACTOR = 10,
    parameter int CICLOS_BOCINA    = 20,
    parameter int ANCHO_CONT       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Temperatura,
    input  logic       Manual,
    input  logic       SobreCarga,
    input  logic       Humo,
    input  logic       Reconocer,
    output logic       Bocina,
    output logic       Extractor,
    output logic       Interrupcion,
    output logic [3:0] Causas
);

    // Terminal counts: an event fires on the edge where the counter would
    // reach CICLOS_*, i.e. when it already holds CICLOS_* - 1.
    localparam logic [ANCHO_CONT-1:0] c_filtro_ult = ANCHO_CONT'(CICLOS_FILTRO - 1);
    localparam logic [ANCHO_CONT-1:0] c_ext_ult    = ANCHO_CONT'(CICLOS_EXTRACTOR - 1);
    localparam logic [ANCHO_CONT-1:0] c_boc_ult    = ANCHO_CONT'(CICLOS_BOCINA - 1);
    localparam logic [ANCHO_CONT-1:0] c_max        = '1;

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        ALARMA     = 2'd1,
        SILENCIADA = 2'd2
    } estado_t;

    logic [3:0] w_raw;
    logic [3:0] w_filt;
    logic       w_req_ext;
    logic       w_req_boc;
    logic       w_req_int;

    // Bit order matches Causas: {Temperatura, Manual, SobreCarga, Humo}
    assign w_raw = {Temperatura, Manual, SobreCarga, Humo};

    // ------------------------------------------------------------------
    // Input filters: the filtered bit follows the raw input only after
    // CICLOS_FILTRO consecutive differing samples.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 4; i++) begin : g_filtro
        logic [ANCHO_CONT-1:0] r_cnt;
        logic                  r_f;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
                r_f   <= 1'b0;
            end else if (w_raw[i] != r_f) begin
                if (r_cnt >= c_filtro_ult) begin
                    r_f   <= w_raw[i];
                    r_cnt <= '0;
                end else if (r_cnt != c_max) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end

        assign w_filt[i] = r_f;
    end

    // w_filt[0]=Humo, [1]=SobreCarga, [2]=Manual, [3]=Temperatura
    assign w_req_ext = w_filt[0] | w_filt[2];
    assign w_req_boc = w_req_ext | w_filt[3];
    assign w_req_int = w_filt[1] | w_filt[2];

    // ------------------------------------------------------------------
    // Latched causes and power cut: set wins over acknowledge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            Causas       <= 4'b0000;
            Interrupcion <= 1'b0;
        end else begin
            Causas       <= w_filt | (Causas & {4{~Reconocer}});
            Interrupcion <= w_req_int | (Interrupcion & ~Reconocer);
        end
    end

    // ------------------------------------------------------------------
    // Fan: on while requested, then held for CICLOS_EXTRACTOR cycles.
    // A renewed request clears the hold counter.
    // ------------------------------------------------------------------
    logic [ANCHO_CONT-1:0] r_cnt_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            Extractor <= 1'b0;
            r_cnt_ext <= '0;
        end else if (w_req_ext) begin
            Extractor <= 1'b1;
            r_cnt_ext <= '0;
        end else if (Extractor) begin
            if (r_cnt_ext >= c_ext_ult) begin
                Extractor <= 1'b0;
                r_cnt_ext <= '0;
            end else if (r_cnt_ext != c_max) begin
                r_cnt_ext <= r_cnt_ext + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Horn FSM with registered output.
    // ------------------------------------------------------------------
    estado_t               r_estado;
    logic [ANCHO_CONT-1:0] r_cnt_boc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado  <= REPOSO;
            r_cnt_boc <= '0;
            Bocina    <= 1'b0;
        end else begin
            case (r_estado)
                REPOSO: begin
                    if (w_req_boc) begin
                        r_estado <= ALARMA;
                        Bocina   <= 1'b1;
                    end
                end
                ALARMA: begin
                    // Holds even without a request until acknowledged
                    if (Reconocer) begin
                        r_estado  <= SILENCIADA;
                        r_cnt_boc <= '0;
                        Bocina    <= 1'b0;
                    end
                end
                SILENCIADA: begin
                    // Acknowledge is ignored here so a held button cannot
                    // suppress the re-arm.
                    if (!w_req_boc) begin
                        r_estado  <= REPOSO;
                        r_cnt_boc <= '0;
                    end else if (r_cnt_boc >= c_boc_ult) begin
                        r_estado  <= ALARMA;
                        r_cnt_boc <= '0;
                        Bocina    <= 1'b1;
                    end else if (r_cnt_boc != c_max) begin
                        r_cnt_boc <= r_cnt_boc + 1'b1;
                    end
                end
                default: begin
                    r_estado  <= REPOSO;
                    r_cnt_boc <= '0;
                    Bocina    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controlador_de_alarmas.sv
`default_nettype none
// ============================================================================
// Module     : tb_controlador_de_alarmas
// Description: Self-checking bench for controlador_de_alarmas. Directed
//              scenarios followed by a randomized phase, all compared each
//              cycle against a timestamp-based reference model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_controlador_de_alarmas;

    localparam int CF = 4;
    localparam int CE = 10;
    localparam int CB = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Temperatura = 1'b0;
    logic       Manual = 1'b0;
    logic       SobreCarga = 1'b0;
    logic       Humo = 1'b0;
    logic       Reconocer = 1'b0;
    logic       Bocina;
    logic       Extractor;
    logic       Interrupcion;
    logic [3:0] Causas;

    int total = 0;
    int bad = 0;

    controlador_de_alarmas #(
        .CICLOS_FILTRO   (CF),
        .CICLOS_EXTRACTOR(CE),
        .CICLOS_BOCINA   (CB),
        .ANCHO_CONT      (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Temperatura (Temperatura),
        .Manual      (Manual),
        .SobreCarga  (SobreCarga),
        .Humo        (Humo),
        .Reconocer   (Reconocer),
        .Bocina      (Bocina),
        .Extractor   (Extractor),
        .Interrupcion(Interrupcion),
        .Causas      (Causas)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Filtered value flips once the last CF raw samples since reset all
    // differ from it. Fan is on while fewer than CE edges have passed since
    // the last edge that saw a fan request. Horn mode: 0 idle, 1 sounding,
    // 2 silenced since edge m_sil_desde.
    logic [3:0] m_hist[$];
    logic [3:0] m_f = 4'b0;
    logic [3:0] m_causas = 4'b0;
    logic       m_int = 1'b0;
    int         m_modo = 0;
    int         m_sil_desde = 0;
    int         m_ult_ext = -1000000;
    int         k = 0;
    string      scen = "reset";

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", scen, tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [3:0] raw;
        logic [3:0] nf;
        logic       r_ext, r_boc, r_int, todos;
        k++;
        raw = {Temperatura, Manual, SobreCarga, Humo};
        if (reset) begin
            m_hist.delete();
            m_f = 4'b0; m_causas = 4'b0; m_int = 1'b0;
            m_modo = 0; m_ult_ext = -1000000;
        end else begin
            r_ext = m_f[0] | m_f[2];
            r_boc = r_ext | m_f[3];
            r_int = m_f[1] | m_f[2];
            m_causas = m_f | (Reconocer ? 4'b0 : m_causas);
            m_int = r_int | (m_int & ~Reconocer);
            if (r_ext) m_ult_ext = k;
            case (m_modo)
                0: if (r_boc) m_modo = 1;
                1: if (Reconocer) begin m_modo = 2; m_sil_desde = k; end
                default: begin
                    if (!r_boc) m_modo = 0;
                    else if (k - m_sil_desde >= CB) m_modo = 1;
                end
            endcase
            m_hist.push_front(raw);
            if (m_hist.size() > CF) void'(m_hist.pop_back());
            nf = m_f;
            if (m_hist.size() >= CF) begin
                for (int b = 0; b < 4; b++) begin
                    todos = 1'b1;
                    for (int j = 0; j < CF; j++)
                        if (m_hist[j][b] == m_f[b]) todos = 1'b0;
                    if (todos) nf[b] = raw[b];
                end
            end
            m_f = nf;
        end
        @(posedge clk);
        #1;
        chk("bocina", {3'b0, Bocina}, {3'b0, m_modo == 1});
        chk("extractor", {3'b0, Extractor}, {3'b0, (k - m_ult_ext) < CE});
        chk("interrupcion", {3'b0, Interrupcion}, {3'b0, m_int});
        chk("causas", Causas, m_causas);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        Temperatura = 0; Manual = 0; SobreCarga = 0; Humo = 0; Reconocer = 0;
        tick();
        reset = 1'b0;
    endtask

    int dur[4];

    initial begin
        // Reset state
        do_reset();
        chk("reset_all", {Bocina, Extractor, Interrupcion, 1'b0}, 4'b0);

        // Glitch of 3 cycles is rejected
        scen = "glitch";
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            Humo = (e <= 3);
            tick();
        end
        chk("glitch_out", {Bocina, Extractor, Causas[0], 1'b0}, 4'b0);

        // Smoke: horn+fan at edge 5, fan off 10 cycles after filtered fall
        scen = "humo";
        do_reset();
        for (int e = 1; e <= 45; e++) begin
            Humo = (e < 30);
            tick();
            if (e == 4) chk("boc_e4", {3'b0, Bocina}, 4'd0);
            if (e == 5) chk("boc_ext_e5", {2'b0, Bocina, Extractor}, 4'b0011);
            if (e == 5) chk("causas_e5", Causas, 4'b0001);
            if (e == 42) chk("ext_e42", {3'b0, Extractor}, 4'd1);
            if (e == 43) chk("ext_e43", {3'b0, Extractor}, 4'd0);
        end

        // Temperature: acknowledge silences, re-arms 20 cycles later
        scen = "temp";
        do_reset();
        Temperatura = 1;
        for (int e = 1; e <= 32; e++) begin
            Reconocer = (e == 8);
            tick();
            if (e == 8) chk("boc_sil", {3'b0, Bocina}, 4'd0);
            if (e == 27) chk("boc_e27", {3'b0, Bocina}, 4'd0);
            if (e == 28) chk("boc_rearm", {3'b0, Bocina}, 4'd1);
        end

        // Overload pulse latches the cut; acknowledge clears only when low
        scen = "sobrecarga";
        do_reset();
        for (int e = 1; e <= 26; e++) begin
            SobreCarga = (e <= 6) || (e >= 15);
            Reconocer = (e == 12) || (e == 22);
            tick();
            if (e == 11) chk("int_held", {3'b0, Interrupcion}, 4'd1);
            if (e == 12) chk("int_clr", {2'b0, Interrupcion, Causas[1]}, 4'b0);
            if (e == 22) chk("int_noclr", {2'b0, Interrupcion, Causas[1]}, 4'b0011);
        end

        // Manual alarm and mid-operation reset
        scen = "manual";
        do_reset();
        Manual = 1;
        for (int e = 1; e <= 18; e++) begin
            reset = (e == 12);
            tick();
            if (e == 5) chk("all_on", {1'b0, Bocina, Extractor, Interrupcion}, 4'b0111);
            if (e == 12) chk("rst_off", {1'b0, Bocina, Extractor, Interrupcion}, 4'b0);
            if (e == 16) chk("requal", {1'b0, Bocina, Extractor, Interrupcion}, 4'b0);
            if (e == 17) chk("back_on", {1'b0, Bocina, Extractor, Interrupcion}, 4'b0111);
        end
        reset = 0;

        // Fan hold restarts when the request returns during the hold
        scen = "reasercion";
        do_reset();
        for (int e = 1; e <= 50; e++) begin
            Humo = (e <= 19) || (e >= 24 && e < 35);
            tick();
            if (e >= 5 && e <= 47) chk("ext_hold", {3'b0, Extractor}, 4'd1);
            if (e == 48) chk("ext_off", {3'b0, Extractor}, 4'd0);
        end

        // Randomized phase: held input levels, sparse acknowledges/resets
        scen = "random";
        do_reset();
        for (int b = 0; b < 4; b++) dur[b] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (dur[b] == 0) begin
                    dur[b] = int'($urandom_range(1, 3 * CF + 30));
                    case (b)
                        0: Humo = $urandom_range(0, 2) == 0;
                        1: SobreCarga = $urandom_range(0, 2) == 0;
                        2: Manual = $urandom_range(0, 3) == 0;
                        default: Temperatura = $urandom_range(0, 2) == 0;
                    endcase
                end
                dur[b]--;
            end
            Reconocer = $urandom_range(0, 9) == 0;
            reset = $urandom_range(0, 399) == 0;
            tick();
        end
        reset = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/controlador_de_alarmas.md
CONTROLADOR_DE_ALARMAS -- requirements
Module: controlador_de_alarmas

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
 - CICLOS_FILTRO, 4, consecutive differing samples needed to accept a sensor change (>=1).
 - CICLOS_EXTRACTOR, 10, extractor hold time after its request drops (>=1).
 - CICLOS_BOCINA, 20, silence time before the horn re-arms while a request persists (>=1).
 - ANCHO_CONT, 8, counter width; must hold the largest CICLOS_* value.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
 - clk, in, 1, single clock; all state changes on its rising edge.
 - reset, in, 1, synchronous, active-high.
 - Temperatura, in, 1, raw over-temperature sensor.
 - Manual, in, 1, raw manual alarm pushbutton.
 - SobreCarga, in, 1, raw overload sensor.
 - Humo, in, 1, raw smoke sensor.
 - Reconocer, in, 1, operator acknowledge, level-sampled each cycle.
 - Bocina, out, 1, horn, registered.
 - Extractor, out, 1, fan, registered.
 - Interrupcion, out, 1, power cut, registered and latched.
 - Causas, out, 4, latched causes {Temperatura, Manual, SobreCarga, Humo}, bit 3 to bit 0, registered.
REQ-003 The block SHALL have one clock (clk); reset SHALL be synchronous and active-high.

Function
REQ-004 Each raw input SHALL have its own filter: a counter plus a filtered bit f_x. The counter increments while raw != f_x and clears while raw == f_x.
REQ-005 f_x SHALL take the raw value on the edge where the counter reaches CICLOS_FILTRO; the counter then clears. Pulses shorter than CICLOS_FILTRO cycles SHALL never change f_x.
REQ-006 Request terms from filtered values SHALL be:
 - req_ext = f_Humo | f_Manual
 - req_boc = req_ext | f_Temperatura
 - req_int = f_SobreCarga | f_Manual
REQ-007 Each output SHALL update one edge after the f_x change that causes it. Raw assertion before edge 1 gives f_x at edge CICLOS_FILTRO and the output at edge CICLOS_FILTRO+1.
REQ-008 Causas[i] SHALL set while its f_x=1. It SHALL clear only on a cycle where Reconocer=1 and that f_x=0. Set wins over clear.
REQ-009 The horn FSM SHALL have states REPOSO (Bocina=0), ALARMA (Bocina=1) and SILENCIADA (Bocina=0).
REQ-010 FSM transitions SHALL be:
 - REPOSO -> ALARMA when req_boc=1; Reconocer is ignored in REPOSO.
 - ALARMA -> SILENCIADA when Reconocer=1. ALARMA SHALL hold even if req_boc drops, until acknowledged.
 - SILENCIADA -> REPOSO when req_boc=0.
 - SILENCIADA -> ALARMA after CICLOS_BOCINA consecutive cycles in SILENCIADA with req_boc=1. The silence counter clears on entry to SILENCIADA.
 - Reconocer held high in SILENCIADA SHALL not stop the re-arm.
REQ-011 Extractor SHALL be 1 while req_ext=1. When req_ext falls, Extractor SHALL stay 1 for exactly CICLOS_EXTRACTOR more cycles, then go to 0.
REQ-012 If req_ext reasserts during the extractor hold, the hold counter SHALL clear and the hold SHALL restart on the next fall.
REQ-013 Interrupcion SHALL set when req_int=1 and clear only on a cycle where Reconocer=1 and req_int=0. Set wins over clear.
REQ-014 All counters SHALL saturate, never wrap, at 2^ANCHO_CONT-1.

Reset
REQ-015 While reset=1 at a rising edge, all of the following SHALL clear to 0 on that edge, overriding every other input:
 - Bocina, Extractor, Interrupcion and Causas.
 - All f_x bits and all counters.
 - The FSM, which SHALL go to REPOSO.
REQ-016 Reset asserted mid-operation (ALARMA, extractor hold, latched Interrupcion) SHALL abort it immediately. After release, inputs still high SHALL be re-qualified through the full CICLOS_FILTRO delay.

Verification
REQ-017 Use default parameters. Humo=1 for 3 cycles, then 0 -> Bocina, Extractor and Causas stay 0 (glitch rejected).
REQ-018 Humo=1 held from edge 1 -> Bocina=1 and Extractor=1 at edge 5, Causas=4'b0001. Humo=0 at edge 30 -> Extractor=0 exactly 10 cycles after f_Humo falls.
REQ-019 Temperatura=1 held, then Reconocer pulsed 1 cycle while in ALARMA -> Bocina=0 next edge, then Bocina=1 again 20 cycles later.
REQ-020 SobreCarga pulse of 6 cycles -> Interrupcion=1 and stays 1. Reconocer while SobreCarga=0 -> Interrupcion=0 and Causas[1]=0 next edge. Reconocer applied while SobreCarga is still high -> no clear.
REQ-021 Manual=1 -> Bocina, Extractor and Interrupcion all 1 at edge 5. Reset asserted 1 cycle at edge 12 -> all outputs 0 at edge 12, then back to 1 at edge 17.
REQ-022 Humo falls, reasserts 4 cycles into the extractor hold, then falls again -> Extractor is 1 continuously until 10 cycles after the second fall.
